// File: rtl/line_burst_responder.sv
// Line-to-word burst responder: serves 128-bit cache line reads/writes as eight 16-bit memory beats.
// Optional macro CRITICAL_WORD_FIRST_EN starts read bursts at the requested word instead of word 0.
module line_burst_responder (
    input  logic         clk,
    input  logic         rst,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic [127:0] pmem_rdata,
    output logic         pmem_resp,
    output logic         mem_read,
    output logic         mem_write,
    output logic [15:0]  mem_address,
    output logic [15:0]  mem_wdata,
    output logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_rdata,
    input  logic         mem_resp
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_BEAT = 3'd1,
        RD_GAP  = 3'd2,
        WR_BEAT = 3'd3,
        WR_GAP  = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [11:0]    line_addr;
    logic [127:0]   wdata_q;
    logic [127:0]   line_buf;
    logic [127:0]   line_merged;
    logic [2:0]     beat;
    logic [3:0]     done;
    logic [2:0]     rd_start;
    logic           last_beat;
    logic           addr_unused;

`ifdef CRITICAL_WORD_FIRST_EN
    assign rd_start = pmem_address[3:1];
`else
    assign rd_start = 3'd0;
`endif

    // Offset bits only matter for the read start beat.
    assign addr_unused = ^pmem_address[3:0];
    assign last_beat   = (done == 4'd7);

    always_comb begin
        line_merged = line_buf;
        line_merged[{beat, 4'b0000} +: 16] = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pmem_write) begin
                    state_next = WR_BEAT;
                end else if (pmem_read) begin
                    state_next = RD_BEAT;
                end
            end
            RD_BEAT: begin
                if (mem_resp) begin
                    state_next = last_beat ? RESP : RD_GAP;
                end
            end
            RD_GAP:  state_next = RD_BEAT;
            WR_BEAT: begin
                if (mem_resp) begin
                    state_next = last_beat ? RESP : WR_GAP;
                end
            end
            WR_GAP:  state_next = WR_BEAT;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_addr  <= '0;
            wdata_q    <= '0;
            line_buf   <= '0;
            pmem_rdata <= '0;
            beat       <= '0;
            done       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pmem_write) begin
                        line_addr <= pmem_address[15:4];
                        wdata_q   <= pmem_wdata;
                        beat      <= 3'd0;
                        done      <= 4'd0;
                    end else if (pmem_read) begin
                        line_addr <= pmem_address[15:4];
                        beat      <= rd_start;
                        done      <= 4'd0;
                    end
                end
                RD_BEAT: begin
                    if (mem_resp) begin
                        line_buf <= line_merged;
                        beat     <= beat + 3'd1;
                        done     <= done + 4'd1;
                        // Publish the full line at the edge entering RESP.
                        if (last_beat) begin
                            pmem_rdata <= line_merged;
                        end
                    end
                end
                WR_BEAT: begin
                    if (mem_resp) begin
                        beat <= beat + 3'd1;
                        done <= done + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_read        = (state == RD_BEAT);
        mem_write       = (state == WR_BEAT);
        pmem_resp       = (state == RESP);
        mem_address     = {line_addr, beat, 1'b0};
        mem_wdata       = wdata_q[{beat, 4'b0000} +: 16];
        mem_byte_enable = 2'b11;
    end

endmodule

// File: tb/tb_line_burst_responder.sv
// Randomized bench for line_burst_responder with a word-memory model and per-cycle burst timing reference.
// Honors CRITICAL_WORD_FIRST_EN for the expected read beat order.
module tb_line_burst_responder;

    logic         clk;
    logic         rst;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         mem_read;
    logic         mem_write;
    logic [15:0]  mem_address;
    logic [15:0]  mem_wdata;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_rdata;
    logic         mem_resp;

    line_burst_responder dut (
        .clk             (clk),
        .rst             (rst),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp)
    );

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           lat_cur  = 1;
    int           lat_cnt  = 0;
    bit           spur_en  = 0;
    logic [15:0]  mem_model [0:32767];
    logic [127:0] last_line = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Word memory: responds after lat_cur strobe cycles; random mem_resp noise while idle or gapped.
    always @(negedge clk) begin
        if (mem_read || mem_write) begin
            lat_cnt++;
            if (lat_cnt == lat_cur) begin
                mem_resp = 1'b1;
                if (mem_read) mem_rdata = mem_model[mem_address[15:1]];
                else          mem_model[mem_address[15:1]] = mem_wdata;
            end else begin
                mem_resp  = 1'b0;
                mem_rdata = 16'($urandom);
            end
        end else begin
            lat_cnt   = 0;
            mem_resp  = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = 16'($urandom);
        end
    end

    function automatic logic [2:0] start_beat(input bit is_wr, input logic [15:0] addr);
`ifdef CRITICAL_WORD_FIRST_EN
        return is_wr ? 3'd0 : addr[3:1];
`else
        return 3'd0;
`endif
    endfunction

    function automatic logic [127:0] line_from_model(input logic [15:0] addr);
        logic [127:0] l;
        for (int i = 0; i < 8; i++) l[16*i +: 16] = mem_model[{addr[15:4], 3'(i)}];
        return l;
    endfunction

    task automatic run_txn(input bit wr, input bit both, input logic [15:0] addr,
                           input logic [127:0] wd, input int lat);
        logic [127:0] exp_line;
        logic [2:0]   start;
        logic [2:0]   b;
        bit           strobe_exp;
        int           p;
        int           resp_k;
        bit           eff_wr;
        eff_wr   = wr | both;
        start    = start_beat(eff_wr, addr);
        exp_line = line_from_model(addr);
        resp_k   = 8 * lat + 8;
        lat_cur  = lat;
        @(negedge clk);
        pmem_address = addr;
        pmem_wdata   = wd;
        pmem_write   = eff_wr;
        pmem_read    = !wr | both;
        for (int k = 1; k <= resp_k; k++) begin
            @(negedge clk);
            if (k == 1) begin
                pmem_address = 16'($urandom);
                pmem_wdata   = {4{32'($urandom)}};
            end
            strobe_exp = (k < resp_k) && (((k - 1) % (lat + 1)) < lat);
            p = (k - 1) / (lat + 1);
            b = start + 3'(p);
            check("mem_read", mem_read, strobe_exp && !eff_wr);
            check("mem_write", mem_write, strobe_exp && eff_wr);
            check("pmem_resp", pmem_resp, k == resp_k);
            if (strobe_exp) begin
                check("mem_address", mem_address, {addr[15:4], b, 1'b0});
                if (eff_wr) begin
                    check("mem_wdata", mem_wdata, wd[16*b +: 16]);
                    check("byte_enable", mem_byte_enable, 2'b11);
                end
            end
            if (k == resp_k) begin
                if (eff_wr) begin
                    check("rdata_kept", pmem_rdata, last_line);
                end else begin
                    check("rdata_line", pmem_rdata, exp_line);
                    last_line = exp_line;
                end
                pmem_read  = 1'b0;
                pmem_write = 1'b0;
            end
        end
        @(negedge clk);
        check("idle_after_resp", {pmem_resp, mem_read, mem_write}, 3'b000);
    endtask

    task automatic reset_mid_read(input logic [15:0] addr, input int lat);
        int trig;
        lat_cur = lat;
        trig    = 1 + 4 * (lat + 1);
        @(negedge clk);
        pmem_address = addr;
        pmem_read    = 1'b1;
        for (int k = 1; k <= trig; k++) @(negedge clk);
        check("beat4_strobe", mem_read, 1'b1);
        check("beat4_addr", mem_address, {addr[15:4], start_beat(1'b0, addr) + 3'd4, 1'b0});
        rst = 1'b1;
        @(negedge clk);
        check("rst_strobes", {mem_read, mem_write}, 2'b00);
        check("rst_resp", pmem_resp, 1'b0);
        check("rst_rdata", pmem_rdata, 128'h0);
        last_line = '0;
        rst       = 1'b0;
        pmem_read = 1'b0;
        for (int k = 0; k < 8 * lat + 10; k++) begin
            @(negedge clk);
            check("post_rst_quiet", {pmem_resp, mem_read, mem_write}, 3'b000);
        end
    endtask

    initial begin
        logic [127:0] wd;
        logic [127:0] const_line;
        for (int i = 0; i < 32768; i++) mem_model[i] = 16'($urandom);
        rst          = 1'b1;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        repeat (3) @(negedge clk);
        check("rst_pmem_resp", pmem_resp, 1'b0);
        check("rst_pmem_rdata", pmem_rdata, 128'h0);
        check("rst_mem_strobes", {mem_read, mem_write}, 2'b00);
        check("rst_mem_address", mem_address, 16'h0);
        check("rst_mem_wdata", mem_wdata, 16'h0);
        check("rst_byte_enable", mem_byte_enable, 2'b11);
        rst = 1'b0;
        @(negedge clk);

        // Directed read, L=1, known word pattern.
        for (int i = 0; i < 8; i++) mem_model[{12'h004, 3'(i)}] = 16'h1110 + 16'(i);
        run_txn(1'b0, 1'b0, 16'h0040, '0, 1);
        const_line = 128'h1117_1116_1115_1114_1113_1112_1111_1110;
        check("directed_read_line", pmem_rdata, const_line);

        // Directed write, L=3.
        for (int i = 0; i < 8; i++) wd[16*i +: 16] = 16'hA000 + 16'(i);
        run_txn(1'b1, 1'b0, 16'h1230, wd, 3);
        for (int i = 0; i < 8; i++)
            check("write_landed", mem_model[{12'h123, 3'(i)}], 16'hA000 + 16'(i));

        // Both requests high: write wins.
        run_txn(1'b1, 1'b1, 16'h0050, {4{32'($urandom)}}, 2);

        // Critical-word address; line must match the aligned result.
        run_txn(1'b0, 1'b0, 16'h0046, '0, 1);
        check("cwf_line", pmem_rdata, const_line);

        spur_en = 1'b1;
        reset_mid_read(16'h0046, 2);
        for (int i = 0; i < 8; i++) mem_model[{12'h004, 3'(i)}] = 16'h5550 + 16'(i);
        run_txn(1'b0, 1'b0, 16'h0040, '0, 1);
        check("fresh_after_rst", pmem_rdata[15:0], 16'h5550);

        for (int t = 0; t < 30; t++) begin
            logic [15:0] a;
            a = {8'h00, 8'($urandom)} | 16'h0100 * 16'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check("idle_rdata_stable", pmem_rdata, last_line);
            end
            run_txn(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), a,
                    {4{32'($urandom)}}, $urandom_range(1, 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/line_burst_responder.md
# line_burst_responder

Responder on the cache's physical-memory port. It accepts 128-bit line read and write requests from the L1 cache controller and serves each as an 8-beat sequence of 16-bit word accesses on the word-wide memory port. For reads it assembles the returned words into a line buffer. It sits between the cache datapath (128-bit line, 3-bit index, 9-bit tag, 4-bit offset) and main memory.

## Interface
- No parameters. Line width 128, word width 16 and beat count 8 are fixed by the cache-line geometry.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- pmem_read  in  1  line read request. Held high by the cache until pmem_resp.
- pmem_write  in  1  line write request. Held high by the cache until pmem_resp.
- pmem_address  in  16  line address; bits [3:0] are ignored except under the macro in Configuration.
- pmem_wdata  in  128  write line; word i is bits [16i+15:16i].
- pmem_rdata  out  128  assembled read line.
- pmem_resp  out  1  one-cycle completion strobe.
- mem_read  out  1  word read strobe.
- mem_write  out  1  word write strobe.
- mem_address  out  16  word address, equal to {line_addr[15:4], beat[2:0], 1'b0}.
- mem_wdata  out  16  write word.
- mem_byte_enable  out  2  always 2'b11; line operations are full-word.
- mem_rdata  in  16  read word, valid in a cycle when mem_resp=1.
- mem_resp  in  1  word access complete.

## Operation
- States: IDLE, RD_BEAT, RD_GAP, WR_BEAT, WR_GAP, RESP.
- Acceptance in IDLE:
  - pmem_write=1 → latch address and wdata, beat=start, go to WR_BEAT. Write has priority when both requests are high.
  - Otherwise pmem_read=1 → latch address, beat=start, go to RD_BEAT.
  - start is 0 unless the macro in Configuration is defined.
- RD_BEAT:
  - mem_read=1 and mem_address reflects the current beat.
  - On mem_resp=1: write mem_rdata into slot beat, and advance beat mod 8.
  - If this was the 8th beat, go to RESP; otherwise go to RD_GAP.
- WR_BEAT:
  - mem_write=1 and mem_wdata = latched word[beat].
  - On mem_resp=1, go to RESP if this was the 8th beat, else go to WR_GAP.
- RD_GAP / WR_GAP: all strobes low for exactly one cycle, then return to RD_BEAT / WR_BEAT. The gap guarantees downstream sees a distinct request per beat.
- RESP:
  - pmem_resp=1 for one cycle, then go to IDLE.
  - For reads, pmem_rdata carries the full line in this cycle.
  - The cache deasserts its request in the cycle after pmem_resp.
- A beat counter of 3 bits plus a done count of 0..8 track completion. Beats wrap 7→0.
- pmem_rdata is registered. It holds the last completed read line until the next read's RESP; writes do not alter it.
- Changes on pmem_address, pmem_wdata or the request lines during a burst are ignored.
- mem_resp while in IDLE, a GAP state or RESP is ignored.
- rst mid-burst:
  - Next state is IDLE and strobes are low from the next cycle.
  - The partial line is discarded and pmem_resp is not issued.

## Timing
- Reset values: pmem_resp=0, pmem_rdata=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, mem_byte_enable=2'b11, state IDLE, beat 0.
- All outputs are registered or Moore-decoded from state; there is no combinational path from the pmem_* inputs to outputs.
- Memory latency L is the number of cycles a strobe is high, with mem_resp in its last cycle (L≥1).
- With the request sampled at the edge ending cycle 0:
  - Beat i strobes during cycles 1+i(L+1) … i(L+1)+L.
  - pmem_resp is high in cycle 8L+8.
  - L=1 gives pmem_resp in cycle 16.
- Back-to-back requests: the earliest next acceptance is the edge ending the cycle after RESP.

## Configuration
- CRITICAL_WORD_FIRST_EN
  - Defined: read bursts start at beat = pmem_address[3:1] and wrap mod 8. Each word still lands in its own slot.
  - Not defined: all bursts start at beat 0.
  - Writes always start at beat 0.
  - Latency and the assembled line are identical in both builds.

## Test plan
- Read, L=1, address 16'h0040, memory returns 16'h1110+word_index → mem_address 0x40,0x42,…,0x4E; pmem_resp in cycle 16; pmem_rdata = {16'h1117,…,16'h1110}.
- Write, L=3, address 16'h1230, wdata word i = 16'hA000+i → eight mem_write beats with mem_wdata A000…A007 at 0x1230…0x123E; mem_byte_enable=2'b11; pmem_resp in cycle 32; pmem_rdata unchanged.
- pmem_read and pmem_write both high in IDLE → only mem_write beats occur; one pmem_resp.
- rst asserted during beat 4 of a read → strobes are 0 from the next cycle; no pmem_resp; a subsequent read completes normally with fresh data.
- Macro defined, read at 16'h0046 → beat order 3,4,5,6,7,0,1,2 (addresses 0x46…0x4E, 0x40…0x44); pmem_rdata equals the non-macro result.
- Spurious mem_resp pulses in IDLE and during GAP cycles → no state or data change.
